// File: rtl/img_buf_ctrl_if.sv
// Stream and buffer-port bundle for img_buf_ctrl: source pixels, remap
// coordinates, the four-bank buffer write/read ports and the result stream.
interface img_buf_ctrl_if #(
    parameter int COORD_WIDTH = 16,
    parameter int FRAC_BITS   = 4
);
    logic                   s_valid;
    logic                   s_ready;
    logic [7:0]             s_pixel;

    logic                   c_valid;
    logic                   c_ready;
    logic [COORD_WIDTH-1:0] c_x;
    logic [COORD_WIDTH-1:0] c_y;

    logic [7:0]             buf_pixel;
    logic                   buf_w_en;
    logic [9:0]             buf_wx;
    logic [9:0]             buf_wy;
    logic [9:0]             buf_rx;
    logic [9:0]             buf_ry;
    logic [7:0]             buf_lu;
    logic [7:0]             buf_ru;
    logic [7:0]             buf_ld;
    logic [7:0]             buf_rd;

    logic                   m_valid;
    logic [7:0]             m_lu;
    logic [7:0]             m_ru;
    logic [7:0]             m_ld;
    logic [7:0]             m_rd;
    logic [FRAC_BITS-1:0]   m_fx;
    logic [FRAC_BITS-1:0]   m_fy;
    logic                   m_oob;

    modport master (
        input  s_valid, s_pixel, c_valid, c_x, c_y,
        input  buf_lu, buf_ru, buf_ld, buf_rd,
        output s_ready, c_ready,
        output buf_pixel, buf_w_en, buf_wx, buf_wy, buf_rx, buf_ry,
        output m_valid, m_lu, m_ru, m_ld, m_rd, m_fx, m_fy, m_oob
    );

    modport slave (
        output s_valid, s_pixel, c_valid, c_x, c_y,
        output buf_lu, buf_ru, buf_ld, buf_rd,
        input  s_ready, c_ready,
        input  buf_pixel, buf_w_en, buf_wx, buf_wy, buf_rx, buf_ry,
        input  m_valid, m_lu, m_ru, m_ld, m_rd, m_fx, m_fy, m_oob
    );
endinterface

// File: rtl/img_buf_ctrl.sv
// Frame sequencer for the four-bank interpolation buffer: raster fill, then
// remap-coordinate reads with fractional weights realigned to the 2-cycle buffer.
module img_buf_ctrl #(
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8,
    parameter int COORD_WIDTH = 16,
    parameter int FRAC_BITS   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           frame_done,
    img_buf_ctrl_if.master bus
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int RCW  = $clog2(NPIX + 1);

    localparam logic [9:0]                    WX_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0]                    WY_LAST = 10'(IMG_HEIGHT - 1);
    localparam logic [9:0]                    RX_MAX  = 10'(IMG_WIDTH - 2);
    localparam logic [9:0]                    RY_MAX  = 10'(IMG_HEIGHT - 2);
    localparam logic signed [COORD_WIDTH-1:0] IX_MAX  = COORD_WIDTH'(IMG_WIDTH - 2);
    localparam logic signed [COORD_WIDTH-1:0] IY_MAX  = COORD_WIDTH'(IMG_HEIGHT - 2);
    localparam logic [RCW-1:0]                RD_LAST = RCW'(NPIX - 1);

    typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                 valid;
        logic [FRAC_BITS-1:0] fx;
        logic [FRAC_BITS-1:0] fy;
        logic                 oob;
    } side_t;

    state_t                   state_q, state_d;
    logic [9:0]               wx_q, wx_d, wy_q, wy_d;
    logic [RCW-1:0]           rd_cnt_q, rd_cnt_d;
    logic                     buf_w_en_q, buf_w_en_d;
    logic [7:0]               buf_pixel_q, buf_pixel_d;
    logic [9:0]               buf_wx_q, buf_wx_d, buf_wy_q, buf_wy_d;
    logic [9:0]               buf_rx_q, buf_rx_d, buf_ry_q, buf_ry_d;
    side_t [2:0]              pipe_q, pipe_d;

    logic                     s_rdy, c_rdy, s_hs, c_hs;
    logic signed [COORD_WIDTH-1:0] ix, iy;
    logic                     ix_lo, ix_hi, iy_lo, iy_hi;
    logic [9:0]               rx, ry;

    assign s_hs = bus.s_valid & s_rdy;
    assign c_hs = bus.c_valid & c_rdy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (s_hs && wx_q == WX_LAST && wy_q == WY_LAST) state_d = READ;
            READ:    if (c_hs && rd_cnt_q == RD_LAST) state_d = DRAIN;
            // Stage 2 leaves this cycle, so empty stages 0/1 mean the last result is out.
            DRAIN:   if (!pipe_q[0].valid && !pipe_q[1].valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        frame_done = 1'b0;
        s_rdy      = 1'b0;
        c_rdy      = 1'b0;
        case (state_q)
            IDLE:    busy       = 1'b0;
            FILL:    s_rdy      = 1'b1;
            READ:    c_rdy      = 1'b1;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    // Coordinate decode: clamp decisions use the full signed value before truncation.
    always_comb begin
        ix    = $signed(bus.c_x) >>> FRAC_BITS;
        iy    = $signed(bus.c_y) >>> FRAC_BITS;
        ix_lo = ix[COORD_WIDTH-1];
        iy_lo = iy[COORD_WIDTH-1];
        ix_hi = ix > IX_MAX;
        iy_hi = iy > IY_MAX;
        rx    = ix_lo ? 10'd0 : (ix_hi ? RX_MAX : ix[9:0]);
        ry    = iy_lo ? 10'd0 : (iy_hi ? RY_MAX : iy[9:0]);
    end

    always_comb begin
        wx_d        = wx_q;
        wy_d        = wy_q;
        rd_cnt_d    = rd_cnt_q;
        buf_w_en_d  = s_hs;
        buf_pixel_d = buf_pixel_q;
        buf_wx_d    = buf_wx_q;
        buf_wy_d    = buf_wy_q;
        buf_rx_d    = buf_rx_q;
        buf_ry_d    = buf_ry_q;
        pipe_d[0]   = '0;
        pipe_d[1]   = pipe_q[0];
        pipe_d[2]   = pipe_q[1];

        if (state_q == IDLE) begin
            wx_d     = '0;
            wy_d     = '0;
            rd_cnt_d = '0;
        end

        if (s_hs) begin
            buf_pixel_d = bus.s_pixel;
            buf_wx_d    = wx_q;
            buf_wy_d    = wy_q;
            if (wx_q == WX_LAST) begin
                wx_d = '0;
                wy_d = wy_q + 10'd1;
            end else begin
                wx_d = wx_q + 10'd1;
            end
        end

        if (c_hs) begin
            buf_rx_d  = rx;
            buf_ry_d  = ry;
            rd_cnt_d  = rd_cnt_q + RCW'(1);
            pipe_d[0] = '{valid: 1'b1,
                          fx:    bus.c_x[FRAC_BITS-1:0],
                          fy:    bus.c_y[FRAC_BITS-1:0],
                          oob:   ix_lo | ix_hi | iy_lo | iy_hi};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wx_q        <= '0;
            wy_q        <= '0;
            rd_cnt_q    <= '0;
            buf_w_en_q  <= 1'b0;
            buf_pixel_q <= '0;
            buf_wx_q    <= '0;
            buf_wy_q    <= '0;
            buf_rx_q    <= '0;
            buf_ry_q    <= '0;
            pipe_q      <= '0;
        end else begin
            wx_q        <= wx_d;
            wy_q        <= wy_d;
            rd_cnt_q    <= rd_cnt_d;
            buf_w_en_q  <= buf_w_en_d;
            buf_pixel_q <= buf_pixel_d;
            buf_wx_q    <= buf_wx_d;
            buf_wy_q    <= buf_wy_d;
            buf_rx_q    <= buf_rx_d;
            buf_ry_q    <= buf_ry_d;
            pipe_q      <= pipe_d;
        end
    end

    assign bus.s_ready   = s_rdy;
    assign bus.c_ready   = c_rdy;
    assign bus.buf_w_en  = buf_w_en_q;
    assign bus.buf_pixel = buf_pixel_q;
    assign bus.buf_wx    = buf_wx_q;
    assign bus.buf_wy    = buf_wy_q;
    assign bus.buf_rx    = buf_rx_q;
    assign bus.buf_ry    = buf_ry_q;

    // Neighbours arrive from the buffer already aligned with pipeline stage 2.
    assign bus.m_valid   = pipe_q[2].valid;
    assign bus.m_fx      = pipe_q[2].fx;
    assign bus.m_fy      = pipe_q[2].fy;
    assign bus.m_oob     = pipe_q[2].oob;
    assign bus.m_lu      = bus.buf_lu;
    assign bus.m_ru      = bus.buf_ru;
    assign bus.m_ld      = bus.buf_ld;
    assign bus.m_rd      = bus.buf_rd;

endmodule

// File: tb/tb_img_buf_ctrl.sv
// Directed bench for img_buf_ctrl with a 2-cycle four-bank buffer model and
// a result scoreboard keyed on coordinate acceptance cycle.
module tb_img_buf_ctrl;

    logic clk, rst, start, busy, frame_done;
    int   cyc, checks, failures;

    img_buf_ctrl_if #(.COORD_WIDTH(16), .FRAC_BITS(4)) bus ();

    img_buf_ctrl #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .COORD_WIDTH(16), .FRAC_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    typedef struct packed {
        logic [7:0] lu, ru, ld, rd;
        logic [3:0] fx, fy;
        logic       oob;
    } res_t;

    typedef struct {
        int   due;
        res_t r;
    } sb_t;

    logic [7:0] img [64];
    logic [7:0] mem [64];
    res_t       res_log [64];
    sb_t        sb [$];
    int         widx, mv_cnt, done_cnt, res_k, last_mv_cyc, done_cyc;
    bit         mon_en, wr_pend;
    int         r1x, r1y;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buffer model: address register, then data register (outputs valid two cycles after buf_rx).
    always @(posedge clk) begin
        int wi;
        wi = int'(bus.buf_wy) * 8 + int'(bus.buf_wx);
        if (bus.buf_w_en && wi < 64) mem[wi] <= bus.buf_pixel;
        r1x        <= int'(bus.buf_rx);
        r1y        <= int'(bus.buf_ry);
        bus.buf_lu <= mem[(r1y * 8 + r1x) & 63];
        bus.buf_ru <= mem[(r1y * 8 + r1x + 1) & 63];
        bus.buf_ld <= mem[((r1y + 1) * 8 + r1x) & 63];
        bus.buf_rd <= mem[((r1y + 1) * 8 + r1x + 1) & 63];
    end

    function automatic res_t model(input logic [15:0] cx, input logic [15:0] cy);
        int   ix, iy, rx, ry;
        res_t r;
        ix    = int'($signed(cx)) >>> 4;
        iy    = int'($signed(cy)) >>> 4;
        rx    = (ix < 0) ? 0 : ((ix > 6) ? 6 : ix);
        ry    = (iy < 0) ? 0 : ((iy > 6) ? 6 : iy);
        r.lu  = img[ry * 8 + rx];
        r.ru  = img[ry * 8 + rx + 1];
        r.ld  = img[(ry + 1) * 8 + rx];
        r.rd  = img[(ry + 1) * 8 + rx + 1];
        r.fx  = cx[3:0];
        r.fy  = cy[3:0];
        r.oob = (ix < 0) || (ix > 6) || (iy < 0) || (iy > 6);
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            res_t act;
            sb_t  e;
            check("buf_w_en", bus.buf_w_en, wr_pend);
            if (bus.buf_w_en) begin
                check("wr_port", {bus.buf_wy, bus.buf_wx, bus.buf_pixel},
                      {10'(widx / 8), 10'(widx % 8), img[widx % 64]});
                widx++;
            end
            wr_pend = bus.s_valid && bus.s_ready && !rst;

            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("m_missing", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            if (bus.m_valid) begin
                mv_cnt++;
                last_mv_cyc = cyc;
                act = {bus.m_lu, bus.m_ru, bus.m_ld, bus.m_rd, bus.m_fx, bus.m_fy, bus.m_oob};
                if (res_k < 64) res_log[res_k] = act;
                res_k++;
                check("m_spurious", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("m_latency", cyc, e.due);
                    check("m_result", act, e.r);
                end
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.c_valid && bus.c_ready && !rst)
                sb.push_back('{due: cyc + 3, r: model(bus.c_x, bus.c_y)});
        end
    end

    task automatic new_frame();
        widx     = 0;
        mv_cnt   = 0;
        done_cnt = 0;
        res_k    = 0;
        tick(); start = 1'b1;
        @(negedge clk);
        tick(); start = 1'b0;
        @(negedge clk);
        check("start_fill", {busy, bus.s_ready, bus.c_ready}, 3'b110);
    endtask

    task automatic send_pix(input logic [7:0] p, input int gap, input bit c_noise);
        int n = 0;
        bit hs = 1'b0;
        while (!hs && n < 200) begin
            tick();
            bus.s_valid = ($urandom_range(99) >= gap);
            bus.s_pixel = p;
            bus.c_valid = c_noise;
            bus.c_x     = 16'h0020;
            bus.c_y     = 16'h0030;
            @(negedge clk);
            if (c_noise) check("fill_c_ready", bus.c_ready, 0);
            hs = bus.s_valid && bus.s_ready;
            n++;
        end
        check("pix_accepted", hs, 1);
    endtask

    task automatic fill(input int gap, input bit c_noise);
        for (int i = 0; i < 64; i++) send_pix(img[i], gap, c_noise);
    endtask

    task automatic send_coord(input logic [15:0] cx, input logic [15:0] cy, input int gap);
        int n = 0;
        bit hs = 1'b0;
        while (!hs && n < 200) begin
            tick();
            bus.s_valid = 1'b0;
            bus.c_valid = ($urandom_range(99) >= gap);
            bus.c_x     = cx;
            bus.c_y     = cy;
            @(negedge clk);
            hs = bus.c_valid && bus.c_ready;
            n++;
        end
        check("coord_accepted", hs, 1);
    endtask

    task automatic issue_one(input logic [15:0] cx, input logic [15:0] cy,
                             output logic [19:0] rxry, output logic v2, output logic [41:0] t3);
        tick();
        bus.s_valid = 1'b0;
        bus.c_valid = 1'b1;
        bus.c_x     = cx;
        bus.c_y     = cy;
        @(negedge clk);
        check("issue_c_ready", bus.c_ready, 1);
        tick(); bus.c_valid = 1'b0;
        @(negedge clk); rxry = {bus.buf_rx, bus.buf_ry};
        tick();
        @(negedge clk); v2 = bus.m_valid;
        tick();
        @(negedge clk);
        t3 = {bus.m_valid, bus.m_lu, bus.m_ru, bus.m_ld, bus.m_rd, bus.m_fx, bus.m_fy, bus.m_oob};
    endtask

    task automatic end_frame(input string tag);
        int n = 0;
        tick();
        bus.c_valid = 1'b0;
        bus.s_valid = 1'b0;
        while (done_cnt == 0 && n < 40) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check({tag, "_mv_cnt"}, mv_cnt, 64);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cyc"}, done_cyc, last_mv_cyc + 1);
        check({tag, "_idle"}, {busy, bus.s_ready, bus.c_ready}, 3'b000);
    endtask

    initial begin
        logic [19:0] rxry;
        logic        v2;
        logic [41:0] t3;

        rst         = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_pixel = '0;
        bus.c_valid = 1'b0;
        bus.c_x     = '0;
        bus.c_y     = '0;
        mon_en      = 1'b0;
        wr_pend     = 1'b0;
        checks      = 0;
        failures    = 0;
        for (int i = 0; i < 64; i++) img[i] = 8'(i);

        repeat (3) tick();
        @(negedge clk);
        check("rst_ctrl", {busy, frame_done, bus.s_ready, bus.c_ready, bus.buf_w_en, bus.m_valid, bus.m_oob}, 0);
        check("rst_ports", {bus.buf_pixel, bus.buf_wx, bus.buf_wy, bus.buf_rx, bus.buf_ry}, 0);
        check("rst_frac", {bus.m_fx, bus.m_fy}, 0);
        tick(); rst = 1'b0; mon_en = 1'b1;
        @(negedge clk);
        check("idle_ctrl", {busy, bus.s_ready, bus.c_ready, frame_done}, 0);

        // Frame 1: ramp fill and identity remap, both back-to-back.
        new_frame();
        fill(0, 1'b0);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                send_coord(16'(x << 4), 16'(y << 4), 0);
        end_frame("id");
        check("id_2_3", res_log[26], {8'd26, 8'd27, 8'd34, 8'd35, 4'd0, 4'd0, 1'b0});
        check("id_0_0", res_log[0], {8'd0, 8'd1, 8'd8, 8'd9, 4'd0, 4'd0, 1'b0});

        // Frame 2: gapped fill with coordinate noise, directed reads, protocol isolation.
        new_frame();
        fill(30, 1'b1);
        tick(); bus.s_valid = 1'b0; bus.c_valid = 1'b0;
        @(negedge clk);
        check("fill_no_read", {bus.buf_rx, bus.buf_ry}, {10'd6, 10'd6});
        check("read_entered", {bus.s_ready, bus.c_ready}, 2'b01);

        issue_one(16'h0025, 16'h0018, rxry, v2, t3);
        check("frac_rx_ry", rxry, {10'd2, 10'd1});
        check("frac_t2_idle", v2, 0);
        check("frac_valid", t3[41], 1);
        check("frac_fx_fy", t3[8:1], {4'd5, 4'd8});
        check("frac_lu", t3[40:33], 8'd10);

        issue_one(16'hFFF0, 16'h0070, rxry, v2, t3);
        check("clamp_rx_ry", rxry, {10'd0, 10'd6});
        check("clamp_oob", {t3[41], t3[0]}, 2'b11);
        check("clamp_lu", t3[40:33], 8'd48);

        issue_one(16'h0060, 16'h0060, rxry, v2, t3);
        check("edge_rx_ry", rxry, {10'd6, 10'd6});
        check("edge_oob", {t3[41], t3[0]}, 2'b10);
        check("edge_rd", t3[16:9], 8'd63);

        for (int i = 0; i < 4; i++) begin
            tick(); bus.s_valid = 1'b1; bus.s_pixel = 8'hAA;
            @(negedge clk);
            check("read_s_ready", bus.s_ready, 0);
        end
        tick(); bus.s_valid = 1'b0;
        @(negedge clk);
        check("read_no_write", bus.buf_w_en, 0);

        tick(); start = 1'b1;
        @(negedge clk);
        tick(); start = 1'b0;
        @(negedge clk);
        check("start_ignored", {busy, bus.s_ready, bus.c_ready}, 3'b101);

        for (int k = 0; k < 61; k++)
            send_coord(16'($urandom_range(0, 191)) - 16'd32, 16'($urandom_range(0, 191)) - 16'd32, 30);
        end_frame("gap");

        // Frame 3: abort with results in flight.
        new_frame();
        fill(0, 1'b0);
        for (int k = 0; k < 20; k++) send_coord(16'((k % 8) << 4), 16'((k / 8) << 4), 0);
        tick(); bus.c_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        tick(); rst = 1'b0; sb.delete(); mv_cnt = 0; done_cnt = 0;
        @(negedge clk);
        check("abort_busy", {busy, bus.m_valid, bus.c_ready}, 3'b000);
        repeat (8) tick();
        check("abort_no_mv", mv_cnt, 0);
        check("abort_no_done", done_cnt, 0);

        // Frame 4: clean frame over stale buffer, new image, wide coordinate range.
        for (int i = 0; i < 64; i++) img[i] = 8'(i * 37 + 11);
        new_frame();
        fill(30, 1'b0);
        for (int k = 0; k < 64; k++) begin
            if (k % 2 == 0)
                send_coord(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 30);
            else
                send_coord(16'($urandom_range(0, 127)), 16'($urandom_range(0, 127)), 30);
        end
        end_frame("clean");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/img_buf_ctrl.md
# img_buf_ctrl

Frame sequencer for the four-bank interpolation image buffer in the rectify fetch path. It loads one source frame into the buffer from a valid/ready pixel stream in raster order. It then accepts a stream of fixed-point remap coordinates, issues buffer reads, and re-aligns the buffer's 2-cycle neighbour outputs with the fractional weights and an out-of-bounds flag for the downstream bilinear interpolator.

## Interface
- IMG_WIDTH, 8, source/destination frame width in pixels (even, ≥4, ≤1024)
- IMG_HEIGHT, 8, frame height in pixels (even, ≥4, ≤1024)
- COORD_WIDTH, 16, width of signed remap coordinates
- FRAC_BITS, 4, fractional bits in remap coordinates
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a frame (honoured only in IDLE)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the last result has left the pipeline
- s_valid, s_ready  in/out  1  source pixel handshake
- s_pixel  in  8  source pixel
- c_valid, c_ready  in/out  1  remap coordinate handshake
- c_x, c_y  in  COORD_WIDTH  signed coordinates, Q(COORD_WIDTH−FRAC_BITS).FRAC_BITS
- buf_pixel  out  8; buf_w_en  out  1; buf_wx, buf_wy  out  10  buffer write port
- buf_rx, buf_ry  out  10  buffer read coordinates
- buf_lu, buf_ru, buf_ld, buf_rd  in  8  buffer neighbour outputs
- m_valid  out  1  result strobe (no backpressure; downstream always accepts)
- m_lu, m_ru, m_ld, m_rd  out  8  neighbour pixels
- m_fx, m_fy  out  FRAC_BITS  fractional weights
- m_oob  out  1  coordinate fell outside the valid interpolation window

## Operation
- Five states: IDLE, FILL, READ, DRAIN, DONE.
- IDLE: s_ready = c_ready = 0. start → FILL. Write counters and read counters are cleared.
- FILL: s_ready = 1, c_ready = 0. Each handshake performs one buffer write:
  - buf_w_en = 1, buf_pixel = s_pixel, buf_wx/buf_wy = current counters. All four signals are registered.
  - wx increments. It wraps to 0 at IMG_WIDTH−1, and wy increments on the wrap.
  - The handshake at (IMG_WIDTH−1, IMG_HEIGHT−1) → READ.
- READ: s_ready = 0, c_ready = 1. Each coordinate handshake:
  - ix = c_x >>> FRAC_BITS and iy likewise, both arithmetic shifts.
  - fx = c_x[FRAC_BITS−1:0] and fy likewise.
  - oob = (ix < 0) | (ix > IMG_WIDTH−2) | (iy < 0) | (iy > IMG_HEIGHT−2).
  - buf_rx = clamp(ix, 0, IMG_WIDTH−2) and buf_ry = clamp(iy, 0, IMG_HEIGHT−2). The clamp comparison uses the full COORD_WIDTH signed value before truncation to 10 bits.
  - The read counter increments. The IMG_WIDTH·IMG_HEIGHT-th handshake → DRAIN.
- DRAIN: s_ready = c_ready = 0. Stays until the result pipeline holds no valid entry, then → DONE.
- DONE: frame_done = 1 for exactly one cycle, then → IDLE.
- A start pulse in any state other than IDLE is ignored.
- buf_w_en is 0 in every cycle without a FILL handshake. buf_rx/buf_ry hold their last value when no coordinate is accepted.

## Timing
- Reset values: state = IDLE and all counters = 0. Every output is 0: busy, frame_done, s_ready, c_ready, buf_w_en, buf_pixel, buf_wx, buf_wy, buf_rx, buf_ry, m_valid, m_fx, m_fy, m_oob.
- Write: handshake in cycle t → buf_w_en high in cycle t+1 with matching address and data.
- Read: handshake in cycle t → buf_rx/buf_ry presented in cycle t+1 → buf neighbour outputs valid in cycle t+3.
- m_valid, m_fx, m_fy and m_oob pass through a 3-stage valid/sideband shift register and emerge in cycle t+3.
- m_lu/m_ru/m_ld/m_rd are buf_* wired through combinationally. They are meaningful only while m_valid = 1.
- Throughput: one pixel per cycle in FILL, one coordinate per cycle in READ.
- DRAIN lasts exactly 3 cycles after the final read handshake. frame_done is high in the cycle after the final m_valid.
- First cycle of FILL follows the start cycle: s_ready rises in cycle start+1.
- Reset asserted mid-frame:
  - Next cycle is IDLE and the result shift register is cleared.
  - No m_valid or frame_done is emitted for the aborted frame.
  - Buffer contents are left stale, and the next frame overwrites them fully.

## Test plan
- Fill and identity remap:
  - Stimulus: 8×8 ramp pixel = 8·y+x streamed with s_valid held high, then c = (x<<4, y<<4) in raster order.
  - Required: exactly 64 m_valid pulses; for (x,y) = (2,3), m_lu = 26, m_ru = 27, m_ld = 34, m_rd = 35, m_fx = m_fy = 0, m_oob = 0.
  - Required: frame_done exactly once, in the cycle after the 64th m_valid.
- Fractional and latency check:
  - Stimulus: c = (0x0025, 0x0018) accepted in cycle t.
  - Required: buf_rx = 2 and buf_ry = 1 in cycle t+1; m_valid in cycle t+3 with m_fx = 5, m_fy = 8, m_lu = 10.
- Boundary clamp:
  - Stimulus: c_x = −1 (0xFFF0), c_y = 7<<4.
  - Required: buf_rx = 0, buf_ry = 6, m_oob = 1.
  - Stimulus: c = (6<<4, 6<<4).
  - Required: m_oob = 0, m_rd = 63.
- Backpressure gaps:
  - Stimulus: random s_valid/c_valid gaps (~30% low).
  - Required: write addresses remain strictly raster; m_valid count = 64; results in acceptance order with the 3-cycle offset.
- Protocol isolation:
  - Stimulus: c_valid asserted during FILL.
  - Required: c_ready = 0 and no read issued.
  - Stimulus: s_valid asserted during READ.
  - Required: s_ready = 0 and buf_w_en stays 0.
  - Stimulus: start pulsed during READ.
  - Required: ignored.
- Reset mid-READ:
  - Stimulus: rst pulse after 20 coordinates with 2 results in flight.
  - Required: next cycle busy = 0 and m_valid = 0 thereafter; a following start performs a clean full frame.
